// File: rtl/mem_read_arbiter.sv
// Read-channel arbiter: I$ / D$ refill and stream prefetch onto one memory port.
// One burst in flight; beats are routed back to the granted requester by RID.
module mem_read_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [2:0]              req_arvalid,
  input  logic [3*ADDR_WIDTH-1:0] req_araddr,
  input  logic [3*4-1:0]          req_arlen,
  output logic [2:0]              req_arready,
  output logic [2:0]              req_rvalid,
  output logic [DATA_WIDTH-1:0]   req_rdata,
  output logic                    req_rlast,
  output logic                    mem_arvalid,
  output logic [ADDR_WIDTH-1:0]   mem_araddr,
  output logic [3:0]              mem_arlen,
  output logic [3:0]              mem_arid,
  input  logic                    mem_arready,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic [3:0]              mem_rid,
  input  logic                    mem_rlast,
  output logic                    mem_rready,
  output logic                    prot_err
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t                  state;
  logic [1:0]              grant;
  logic [3:0]              starve_cnt;
  logic [3:0]              beat_cnt;
  logic [3:0]              len_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    rr_last;
  logic                    overrun;
  logic                    err_q;

  logic                    force_pf;
  logic                    pick0;
  logic                    pick1;
  logic                    pick2;
  logic [1:0]              gnt_idx;
  logic [ADDR_WIDTH-1:0]   addr_sel;
  logic [3:0]              len_sel;
  logic                    hit;

  // Picks are mutually exclusive; rr_last=1 means ID 1 was served last.
  always_comb begin
    force_pf = req_arvalid[2] && (starve_cnt == LIMIT);
    pick0 = !force_pf && req_arvalid[0]
            && (!req_arvalid[1] || rr_last);
    pick1 = !force_pf && req_arvalid[1]
            && (!req_arvalid[0] || !rr_last);
    pick2 = req_arvalid[2]
            && (force_pf || !(req_arvalid[0] || req_arvalid[1]));
    gnt_idx = 2'd0;
    unique case (1'b1)
      pick0:   gnt_idx = 2'd0;
      pick1:   gnt_idx = 2'd1;
      pick2:   gnt_idx = 2'd2;
      default: gnt_idx = 2'd0;
    endcase
  end

  always_comb begin
    addr_sel = '0;
    len_sel  = '0;
    for (int i = 0; i < 3; i++) begin
      if (gnt_idx == 2'(i)) begin
        addr_sel = req_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        len_sel  = req_arlen[i*4 +: 4];
      end
    end
  end

  assign hit = (state == DATA) && mem_rvalid
               && (mem_rid == {2'b00, grant});

  assign req_arready = (state == IDLE) ? {pick2, pick1, pick0} : 3'b000;
  assign req_rvalid  = hit ? (3'b001 << grant) : 3'b000;
  assign req_rdata   = mem_rdata;
  assign req_rlast   = hit && mem_rlast;
  assign mem_arvalid = (state == ADDR);
  assign mem_araddr  = addr_q;
  assign mem_arlen   = len_q;
  assign mem_arid    = {2'b00, grant};
  assign mem_rready  = 1'b1;
  assign prot_err    = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= 2'd0;
      starve_cnt <= 4'd0;
      beat_cnt   <= 4'd0;
      len_q      <= 4'd0;
      addr_q     <= '0;
      rr_last    <= 1'b1;
      overrun    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick0 || pick1 || pick2) begin
            grant  <= gnt_idx;
            addr_q <= addr_sel;
            len_q  <= len_sel;
            state  <= ADDR;
            if (pick0) rr_last <= 1'b0;
            if (pick1) rr_last <= 1'b1;
            if (pick2 || !req_arvalid[2])
              starve_cnt <= 4'd0;
            else if (starve_cnt != LIMIT)
              starve_cnt <= starve_cnt + 4'd1;
          end
        end
        ADDR: begin
          if (mem_arready) begin
            state    <= DATA;
            beat_cnt <= 4'd0;
            overrun  <= 1'b0;
          end
        end
        DATA: begin
          if (mem_rvalid) begin
            if (!hit) begin
              err_q <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + 4'd1;
              if (mem_rlast) begin
                state <= IDLE;
                if (beat_cnt != len_q || overrun) err_q <= 1'b1;
              end else if (beat_cnt == len_q || overrun) begin
                // Missing rlast: every further beat is a protocol error.
                overrun <= 1'b1;
                err_q   <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Bench for mem_read_arbiter: vector table of bursts plus hand-built
// sequences for bad RID, early rlast and reset in the middle of a burst.
module tb_mem_read_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    req_arvalid;
  logic [3*AW-1:0] req_araddr;
  logic [11:0]   req_arlen;
  logic [2:0]    req_arready;
  logic [2:0]    req_rvalid;
  logic [DW-1:0] req_rdata;
  logic          req_rlast;
  logic          mem_arvalid;
  logic [AW-1:0] mem_araddr;
  logic [3:0]    mem_arlen;
  logic [3:0]    mem_arid;
  logic          mem_arready;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic [3:0]    mem_rid;
  logic          mem_rlast;
  logic          mem_rready;
  logic          prot_err;

  mem_read_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_arvalid(req_arvalid), .req_araddr(req_araddr),
    .req_arlen(req_arlen), .req_arready(req_arready),
    .req_rvalid(req_rvalid), .req_rdata(req_rdata),
    .req_rlast(req_rlast),
    .mem_arvalid(mem_arvalid), .mem_araddr(mem_araddr),
    .mem_arlen(mem_arlen), .mem_arid(mem_arid),
    .mem_arready(mem_arready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_rid(mem_rid),
    .mem_rlast(mem_rlast), .mem_rready(mem_rready),
    .prot_err(prot_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    v;
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  typedef struct {
    logic [2:0] mask;
    logic [1:0] g;
    int         len;
    int         dly;
    int         nb;
    logic       perr;
  } vec_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  localparam logic [AW-1:0] A0 = 32'h0000_2000;
  localparam logic [AW-1:0] A1 = 32'h0000_3000;
  localparam logic [AW-1:0] A2 = 32'h0000_0100;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] exp_addr(input logic [1:0] g);
    case (g)
      2'd0:    return A0;
      2'd1:    return A1;
      default: return A2;
    endcase
  endfunction

  task automatic beat(input logic [3:0] rid, input logic last,
                      input logic [2:0] ev);
    exp_t e;
    mem_rvalid = 1'b1;
    mem_rid    = rid;
    mem_rlast  = last;
    mem_rdata  = $urandom;
    e.v = ev;
    e.d = mem_rdata;
    e.l = last;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    chk("rvalid", req_rvalid, e.v);
    if (e.v != 3'b000) begin
      chk("rdata", req_rdata, e.d);
      chk("rlast", req_rlast, e.l);
    end
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    mem_rlast  = 1'b0;
  endtask

  task automatic xact(input logic [2:0] mask, input logic [1:0] g,
                      input int len, input int dly, input int nb);
    @(negedge clk);
    req_arvalid = mask;
    req_arlen   = {3{4'(len)}};
    #1;
    chk("arready_grant", req_arready, 3'b001 << g);
    @(posedge clk); #1;
    for (int i = 0; i <= dly; i++) begin
      chk("mem_arvalid", mem_arvalid, 1'b1);
      chk("mem_arid", mem_arid, {2'b00, g});
      chk("mem_araddr", mem_araddr, exp_addr(g));
      chk("mem_arlen", mem_arlen, 4'(len));
      chk("arready_busy", req_arready, 3'b000);
      mem_arready = (i == dly);
      @(posedge clk); #1;
    end
    mem_arready = 1'b0;
    for (int b = 0; b < nb; b++)
      beat({2'b00, g}, b == nb - 1, 3'b001 << g);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    req_arvalid = 3'b000;
    mem_rvalid  = 1'b0;
    mem_rlast   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_arready"}, req_arready, 3'b000);
    chk({tag, "_rvalid"}, req_rvalid, 3'b000);
    chk({tag, "_mem_arvalid"}, mem_arvalid, 1'b0);
    chk({tag, "_mem_araddr"}, mem_araddr, '0);
    chk({tag, "_mem_arlen"}, mem_arlen, 4'd0);
    chk({tag, "_mem_arid"}, mem_arid, 4'd0);
    chk({tag, "_mem_rready"}, mem_rready, 1'b1);
    chk({tag, "_prot_err"}, prot_err, 1'b0);
  endtask

  vec_t vecs[16];

  initial begin
    vecs[0] = '{3'b100, 2'd2, 3, 2, 4, 1'b0};
    vecs[1] = '{3'b011, 2'd0, 1, 0, 2, 1'b0};
    vecs[2] = '{3'b011, 2'd1, 1, 1, 2, 1'b0};
    vecs[3] = '{3'b011, 2'd0, 1, 0, 2, 1'b0};
    vecs[4] = '{3'b011, 2'd1, 1, 0, 2, 1'b0};
    for (int i = 0; i < 10; i++)
      vecs[5+i] = '{3'b101, (i % 5 == 4) ? 2'd2 : 2'd0,
                    0, i % 2, 1, 1'b0};
    vecs[15] = '{3'b010, 2'd1, 2, 0, 3, 1'b0};

    rst_n       = 1'b0;
    req_arvalid = 3'b000;
    req_araddr  = {A2, A1, A0};
    req_arlen   = '0;
    mem_arready = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rdata   = '0;
    mem_rid     = '0;
    mem_rlast   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      xact(vecs[i].mask, vecs[i].g, vecs[i].len,
           vecs[i].dly, vecs[i].nb);
      chk("vec_prot_err", prot_err, vecs[i].perr);
    end
    req_arvalid = 3'b000;
    #1;
    chk("idle_no_grant", req_arready, 3'b000);
    chk("idle_no_arvalid", mem_arvalid, 1'b0);

    // Early rlast: len 3 but last flagged on the 2nd beat.
    xact(3'b010, 2'd1, 3, 0, 2);
    chk("early_last_err", prot_err, 1'b1);
    xact(3'b001, 2'd0, 0, 0, 1);
    chk("err_sticky", prot_err, 1'b1);
    req_arvalid = 3'b000;

    // Wrong RID during a prefetch burst.
    do_reset();
    chk("rst_clears_err", prot_err, 1'b0);
    req_arvalid = 3'b100;
    req_arlen   = '0;
    #1;
    chk("rid_grant", req_arready, 3'b100);
    @(posedge clk); #1;
    req_arvalid = 3'b000;
    mem_arready = 1'b1;
    @(posedge clk); #1;
    mem_arready = 1'b0;
    beat(4'd1, 1'b0, 3'b000);
    chk("bad_rid_err", prot_err, 1'b1);
    beat(4'd2, 1'b1, 3'b100);
    chk("bad_rid_idle", mem_arvalid, 1'b0);

    // Reset after the first of four beats.
    do_reset();
    req_arvalid = 3'b100;
    req_arlen   = {3{4'd3}};
    #1;
    chk("mid_grant", req_arready, 3'b100);
    @(posedge clk); #1;
    req_arvalid = 3'b000;
    mem_arready = 1'b1;
    @(posedge clk); #1;
    mem_arready = 1'b0;
    beat(4'd2, 1'b0, 3'b100);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_reset_outs("midrst");
    beat(4'd2, 1'b0, 3'b000);
    beat(4'd2, 1'b0, 3'b000);
    beat(4'd2, 1'b1, 3'b000);
    chk("stale_beats_err", prot_err, 1'b0);
    xact(3'b001, 2'd0, 0, 0, 1);
    chk("post_rst_err", prot_err, 1'b0);
    req_arvalid = 3'b000;

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
